mx_block_quantizer: RTL and testbench
=====================================

// Module: mx_block_quantizer
// PURPOSE
// - Inverse of the multiplier-side normalizer: takes normalized BF16-style elements (sign, 8b exp, 7b man)
//   and aligns a block of BLOCK_SIZE elements to one shared exponent, emitting MX-style scale + INT8 elements.
// - Sits between the PE output/normalizer path and the MX writeback buffer; requantizes results to MXINT8.
// PARAMETERS
// - BLOCK_SIZE  32  elements per MX block sharing one scale (power of 2, >=2)
// - EXP_W       8   input exponent / output scale width
// - MAN_W       7   input stored-mantissa width (hidden bit implied)
// PORTS
// - clk        in   1      clock; single clock domain
// - rst        in   1      synchronous, active-high reset
// - in_valid   in   1      input element valid
// - in_ready   out  1      block accepts input element
// - in_sign    in   1      element sign
// - in_exp     in   EXP_W  biased exponent (bias 127)
// - in_man     in   MAN_W  stored mantissa
// - out_valid  out  1      output element valid
// - out_ready  in   1      downstream accepts output element
// - out_scale  out  EXP_W  shared block exponent; constant across a block
// - out_elem   out  8      signed two's-complement element
// - out_first  out  1      high with element 0 of the block
// - out_last   out  1      high with element BLOCK_SIZE-1 of the block
// BEHAVIOUR
// - FSM: COLLECT (in_ready=1) -> EMIT (out_valid=1) -> COLLECT. Single buffer; no overlap of phases.
// - Reset: state=COLLECT; wr_cnt=rd_cnt=0; max_exp=0; nan_flag=0; out_valid=0; out_elem=0; out_scale=0;
//   out_first=out_last=0; in_ready=0 while rst high, 1 from first cycle after release.
// - COLLECT: on in_valid&&in_ready, write {sign,exp,man} to buf[wr_cnt], wr_cnt++, max_exp=max(max_exp,in_exp).
//   in_exp==255 (Inf/NaN) sets nan_flag. Accepting element BLOCK_SIZE-1 -> EMIT next cycle; wr_cnt wraps to 0.
// - Latency: out_valid rises the cycle after the last input handshake; out_scale valid from that cycle.
// - EMIT per element i=rd_cnt: sig = (exp==0) ? 0 : {1,man} (8b; subnormals flush to 0);
//   shift = max_exp - exp (8b unsigned); mag = (shift>=8) ? 0 : ({1'b0,sig} >> (shift+1)) (7b, truncate);
//   out_elem = sign ? -mag : +mag; -0 emitted as 0. Value represented = out_elem * 2^(out_scale-133).
// - out_scale = nan_flag ? 255 : max_exp. nan_flag forces every out_elem of the block to 0.
// - All-zero block: out_scale=0, all elems 0.
// - Handshake: rd_cnt advances only on out_valid&&out_ready; outputs hold stable while out_valid&&!out_ready.
//   in_ready=0 throughout EMIT. Last output handshake -> COLLECT next cycle; clear max_exp, nan_flag, rd_cnt.
// - out_first = out_valid && rd_cnt==0; out_last = out_valid && rd_cnt==BLOCK_SIZE-1.
// - rst at any cycle (mid-COLLECT or mid-EMIT) discards the partial block; next accepted input is element 0.
// - in_valid ignored in EMIT; out_ready ignored in COLLECT. No X on outputs when out_valid=0.
// TESTING (BLOCK_SIZE=4 unless noted; out_ready=1 unless noted)
// - exp {127,127,127,127}, man 0, signs {+,-,+,-} -> scale 127, elems {64,-64,64,-64}, first on e0, last on e3.
// - exp {130,128,127,120}, man 0, all + -> scale 130, elems {64,16,8,0} (shift 10 saturates to 0).
// - {exp127 man7F, exp0 x3} -> scale 127, elems {127,0,0,0}; exp0 man!=0 flushes to 0.
// - one element exp 255 -> scale 255, all four elems 0; next block normal again (flags cleared).
// - out_ready low 3 cycles at element 2 -> out_elem/out_scale/out_last stable, in_ready=0, no drop/duplicate.
// - rst after 2 COLLECT accepts, then 4 new inputs -> block contains only the 4 new inputs; repeat at BLOCK_SIZE=32
//   with random stimulus vs. reference model, back-to-back blocks, in_valid/out_ready toggled randomly.

Source files
------------

// File: rtl/mx_block_quantizer.sv
// Collects a block of normalized sign/exp/man elements, then replays them as MXINT8
// elements aligned to the block's largest exponent (shared scale).
module mx_block_quantizer #(
  parameter int BLOCK_SIZE = 32,
  parameter int EXP_W      = 8,
  parameter int MAN_W      = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [EXP_W-1:0] in_exp,
  input  logic [MAN_W-1:0] in_man,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EXP_W-1:0] out_scale,
  output logic [7:0]       out_elem,
  output logic             out_first,
  output logic             out_last
);

  localparam int CNT_W = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BLOCK_SIZE - 1);
  localparam int ENT_W = 1 + EXP_W + MAN_W;

  typedef enum logic {COLLECT, EMIT} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wr_cnt, rd_cnt;
  logic [EXP_W-1:0] max_exp;
  logic             nan_flag;
  logic [ENT_W-1:0] blk_mem [BLOCK_SIZE];

  // Handshake: a transfer happens on a rising clk edge where valid && ready; the
  // producer holds its data stable while valid && !ready.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      COLLECT: begin
        in_ready = !rst;
        if (in_valid && !rst && wr_cnt == LAST) state_nxt = EMIT;
      end
      EMIT: begin
        out_valid = !rst;
        if (out_ready && !rst && rd_cnt == LAST) state_nxt = COLLECT;
      end
      default: state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= COLLECT;
      wr_cnt   <= '0;
      rd_cnt   <= '0;
      max_exp  <= '0;
      nan_flag <= 1'b0;
    end else begin
      state <= state_nxt;
      if (in_valid && in_ready) begin
        wr_cnt <= wr_cnt + CNT_W'(1);
        if (in_exp > max_exp) max_exp <= in_exp;
        if (in_exp == '1) nan_flag <= 1'b1;
      end
      if (out_valid && out_ready) begin
        if (rd_cnt == LAST) begin
          rd_cnt   <= '0;
          max_exp  <= '0;
          nan_flag <= 1'b0;
        end else begin
          rd_cnt <= rd_cnt + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid && in_ready) blk_mem[wr_cnt] <= {in_sign, in_exp, in_man};
  end

  // Element alignment: the extra +1 in the shift leaves room for the sign bit.
  logic [ENT_W-1:0] rd_ent;
  logic             rd_sign;
  logic [EXP_W-1:0] rd_exp;
  logic [MAN_W-1:0] rd_man;
  logic [MAN_W:0]   sig;
  logic [EXP_W-1:0] shift;
  logic [3:0]       sh_amt;
  logic [6:0]       mag;
  logic [7:0]       pos;

  always_comb begin
    rd_ent  = blk_mem[rd_cnt];
    rd_sign = rd_ent[ENT_W-1];
    rd_exp  = rd_ent[EXP_W+MAN_W-1:MAN_W];
    rd_man  = rd_ent[MAN_W-1:0];
    sig     = (rd_exp == '0) ? '0 : {1'b1, rd_man};
    shift   = max_exp - rd_exp;
    sh_amt  = {1'b0, shift[2:0]} + 4'd1;
    mag     = (shift >= EXP_W'(8)) ? 7'd0 : 7'({1'b0, sig} >> sh_amt);
    pos     = {1'b0, mag};
  end

  assign out_elem  = (!out_valid || nan_flag) ? 8'd0 : (rd_sign ? -pos : pos);
  assign out_scale = !out_valid ? '0 : (nan_flag ? '1 : max_exp);
  assign out_first = out_valid && (rd_cnt == '0);
  assign out_last  = out_valid && (rd_cnt == LAST);

endmodule

// File: tb/tb_mx_block_quantizer.sv
// Directed vector table on a 4-element instance plus a randomized scoreboard
// run on a 32-element instance.
module tb_mx_block_quantizer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 4-element instance
  logic       in_valid, in_ready, in_sign, out_valid, out_ready, out_first, out_last;
  logic [7:0] in_exp, out_scale, out_elem;
  logic [6:0] in_man;

  mx_block_quantizer #(.BLOCK_SIZE(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sign(in_sign),
    .in_exp(in_exp), .in_man(in_man), .out_valid(out_valid), .out_ready(out_ready),
    .out_scale(out_scale), .out_elem(out_elem), .out_first(out_first), .out_last(out_last)
  );

  // 32-element instance
  logic       b_in_valid, b_in_ready, b_in_sign, b_out_valid, b_out_ready, b_out_first, b_out_last;
  logic [7:0] b_in_exp, b_out_scale, b_out_elem;
  logic [6:0] b_in_man;

  mx_block_quantizer #(.BLOCK_SIZE(32)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_sign(b_in_sign),
    .in_exp(b_in_exp), .in_man(b_in_man), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_scale(b_out_scale), .out_elem(b_out_elem), .out_first(b_out_first), .out_last(b_out_last)
  );

  int checks = 0;
  int errors = 0;
  logic [17:0] exp_q[$];

  typedef struct {
    logic       s[4];
    logic [7:0] e[4];
    logic [6:0] m[4];
    logic [7:0] scale;
    logic [7:0] elem[4];
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=handshake at %0t", name, $time);
  endtask

  function automatic logic [7:0] ref_elem(input logic s, input logic [7:0] e,
                                          input logic [6:0] m, input logic [7:0] mx);
    int sig, sh, mag;
    sig = (e == 0) ? 0 : (128 + int'(m));
    sh  = int'(mx) - int'(e);
    mag = (sh >= 8) ? 0 : (sig / (2 ** (sh + 1)));
    return s ? 8'(-mag) : 8'(mag);
  endfunction

  task automatic push(input logic s, input logic [7:0] e, input logic [6:0] m);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_sign = s; in_exp = e; in_man = m;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) fail("push_wait");
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic pop(input logic [7:0] elem, input logic [7:0] scale,
                     input logic first, input logic last, input string tag);
    int n = 0;
    @(negedge clk);
    out_ready = 1'b1;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) fail({tag, "_wait"});
    check({tag, "_elem"}, 32'(out_elem), 32'(elem));
    check({tag, "_scale"}, 32'(out_scale), 32'(scale));
    check({tag, "_first"}, 32'(out_first), 32'(first));
    check({tag, "_last"}, 32'(out_last), 32'(last));
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic run_block(input vec_t v, input string tag);
    for (int i = 0; i < 4; i++) push(v.s[i], v.e[i], v.m[i]);
    @(negedge clk);
    check({tag, "_latency_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_emit_ready"}, 32'(in_ready), 32'd0);
    for (int i = 0; i < 4; i++) pop(v.elem[i], v.scale, i == 0, i == 3, tag);
    @(negedge clk);
    check({tag, "_done_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_done_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_done_elem"}, 32'(out_elem), 32'd0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_ready_low", 32'(in_ready), 32'd0);
    check("rst_valid_low", 32'(out_valid), 32'd0);
    rst = 1'b0;
  endtask

  task automatic producer32();
    logic       s[32];
    logic [7:0] e[32];
    logic [6:0] m[32];
    for (int blk = 0; blk < 4; blk++) begin
      int base, idx, guard, mx;
      logic hold, nan;
      base = $urandom_range(8, 250);
      for (int i = 0; i < 32; i++) begin
        s[i] = 1'($urandom_range(0, 1));
        m[i] = 7'($urandom_range(0, 127));
        e[i] = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'(base - $urandom_range(0, 12));
      end
      if (blk == 1) e[$urandom_range(0, 31)] = 8'd255;
      idx = 0; guard = 0; hold = 1'b0;
      while (idx < 32 && guard < 5000) begin
        @(negedge clk);
        guard++;
        if (!hold) b_in_valid = ($urandom_range(0, 2) != 0);
        if (b_in_valid) begin
          b_in_sign = s[idx]; b_in_exp = e[idx]; b_in_man = m[idx];
        end
        hold = b_in_valid && !b_in_ready;
        if (b_in_valid && b_in_ready) idx++;
      end
      if (idx < 32) fail("rand_producer");
      mx = 0; nan = 1'b0;
      for (int i = 0; i < 32; i++) begin
        if (int'(e[i]) > mx) mx = int'(e[i]);
        if (e[i] == 8'd255) nan = 1'b1;
      end
      for (int i = 0; i < 32; i++)
        exp_q.push_back({i == 0, i == 31, nan ? 8'd255 : 8'(mx),
                         nan ? 8'd0 : ref_elem(s[i], e[i], m[i], 8'(mx))});
    end
    @(negedge clk);
    b_in_valid = 1'b0;
  endtask

  task automatic consumer32();
    int got = 0;
    int cyc = 0;
    logic [17:0] want;
    while (got < 128 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      b_out_ready = ($urandom_range(0, 3) != 0);
      if (b_out_valid && b_out_ready) begin
        if (exp_q.size() == 0) begin
          fail("rand_unexpected_output");
        end else begin
          want = exp_q.pop_front();
          check("rand_elem", 32'({b_out_first, b_out_last, b_out_scale, b_out_elem}), 32'(want));
        end
        got++;
      end
    end
    if (got < 128) fail("rand_consumer");
    @(negedge clk);
    b_out_ready = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_sign = 1'b0; in_exp = 8'd0; in_man = 7'd0; out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_sign = 1'b0; b_in_exp = 8'd0; b_in_man = 7'd0; b_out_ready = 1'b0;

    vecs[0].s = '{1'b0, 1'b1, 1'b0, 1'b1};  vecs[0].e = '{8'd127, 8'd127, 8'd127, 8'd127};
    vecs[0].m = '{7'd0, 7'd0, 7'd0, 7'd0};  vecs[0].scale = 8'd127;
    vecs[0].elem = '{8'd64, 8'hC0, 8'd64, 8'hC0};
    vecs[1].s = '{1'b0, 1'b0, 1'b0, 1'b0};  vecs[1].e = '{8'd130, 8'd128, 8'd127, 8'd120};
    vecs[1].m = '{7'd0, 7'd0, 7'd0, 7'd0};  vecs[1].scale = 8'd130;
    vecs[1].elem = '{8'd64, 8'd16, 8'd8, 8'd0};
    vecs[2].s = '{1'b0, 1'b0, 1'b1, 1'b0};  vecs[2].e = '{8'd127, 8'd0, 8'd0, 8'd0};
    vecs[2].m = '{7'h7F, 7'd0, 7'd5, 7'h7F}; vecs[2].scale = 8'd127;
    vecs[2].elem = '{8'd127, 8'd0, 8'd0, 8'd0};
    vecs[3].s = '{1'b0, 1'b1, 1'b0, 1'b1};  vecs[3].e = '{8'd127, 8'd255, 8'd100, 8'd127};
    vecs[3].m = '{7'd3, 7'd0, 7'd9, 7'd0};  vecs[3].scale = 8'd255;
    vecs[3].elem = '{8'd0, 8'd0, 8'd0, 8'd0};
    vecs[4].s = '{1'b1, 1'b0, 1'b1, 1'b0};  vecs[4].e = '{8'd126, 8'd127, 8'd125, 8'd127};
    vecs[4].m = '{7'h40, 7'd0, 7'h7F, 7'h10}; vecs[4].scale = 8'd127;
    vecs[4].elem = '{8'hD0, 8'd64, 8'hE1, 8'd72};
    vecs[5].s = '{1'b1, 1'b0, 1'b1, 1'b0};  vecs[5].e = '{8'd0, 8'd0, 8'd0, 8'd0};
    vecs[5].m = '{7'd0, 7'd5, 7'h7F, 7'd0}; vecs[5].scale = 8'd0;
    vecs[5].elem = '{8'd0, 8'd0, 8'd0, 8'd0};
    vecs[6].s = '{1'b1, 1'b1, 1'b0, 1'b0};  vecs[6].e = '{8'd135, 8'd129, 8'd128, 8'd127};
    vecs[6].m = '{7'd0, 7'h7F, 7'h7F, 7'h7F}; vecs[6].scale = 8'd135;
    vecs[6].elem = '{8'hC0, 8'hFF, 8'd0, 8'd0};
    vecs[7].s = '{1'b1, 1'b0, 1'b1, 1'b1};  vecs[7].e = '{8'd127, 8'd127, 8'd126, 8'd0};
    vecs[7].m = '{7'h7F, 7'h7F, 7'd0, 7'd0}; vecs[7].scale = 8'd127;
    vecs[7].elem = '{8'h81, 8'd127, 8'hE0, 8'd0};

    // reset state
    @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_in_ready", 32'(in_ready), 32'd1);
    check("post_reset_out_valid", 32'(out_valid), 32'd0);
    check("post_reset_out_elem", 32'(out_elem), 32'd0);
    check("post_reset_out_scale", 32'(out_scale), 32'd0);
    check("post_reset_first_last", 32'({out_first, out_last}), 32'd0);

    for (int i = 0; i < 8; i++) run_block(vecs[i], $sformatf("vec%0d", i));

    // backpressure at element 2, with in_valid asserted to show it is ignored
    for (int i = 0; i < 4; i++) push(vecs[0].s[i], vecs[0].e[i], vecs[0].m[i]);
    pop(vecs[0].elem[0], 8'd127, 1'b1, 1'b0, "stall");
    pop(vecs[0].elem[1], 8'd127, 1'b0, 1'b0, "stall");
    in_valid = 1'b1; in_exp = 8'd200; in_man = 7'd1; in_sign = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_elem", 32'(out_elem), 32'(vecs[0].elem[2]));
      check("stall_scale", 32'(out_scale), 32'd127);
      check("stall_last", 32'(out_last), 32'd0);
      check("stall_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    pop(vecs[0].elem[2], 8'd127, 1'b0, 1'b0, "stall");
    pop(vecs[0].elem[3], 8'd127, 1'b0, 1'b1, "stall");
    run_block(vecs[1], "after_stall");

    // reset mid-COLLECT: partial block with a larger exponent must vanish
    push(1'b0, 8'd140, 7'd0);
    push(1'b1, 8'd140, 7'd0);
    pulse_reset();
    run_block(vecs[1], "rst_collect");

    // reset mid-EMIT
    for (int i = 0; i < 4; i++) push(vecs[3].s[i], vecs[3].e[i], vecs[3].m[i]);
    pop(8'd0, 8'd255, 1'b1, 1'b0, "pre_rst_emit");
    pulse_reset();
    run_block(vecs[4], "rst_emit");

    // randomized back-to-back blocks at BLOCK_SIZE=32
    fork
      producer32();
      consumer32();
    join
    check("rand_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
